// File: rtl/counter_pkg.sv
// Shared types and constants for the modulo up/down counter.
// Boundary mode selection and direction encodings.
package counter_pkg;

   typedef enum logic {
      COUNT_WRAP = 1'b0,
      COUNT_SAT  = 1'b1
   } count_mode_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/modulo_updown_counter_if.sv
// Control and status bundle of the modulo up/down counter.
// master drives the controls, slave is the counter side.
interface modulo_updown_counter_if #(
   parameter int SIZE = 8
);

   logic            SR;
   logic            CE;
   logic            DIR;
   logic [SIZE-1:0] SRINIT;
   logic            LOAD;
   logic [SIZE-1:0] LDVAL;
   logic            CLR_OVF;
   logic [SIZE-1:0] DOUT;
   logic            TC;
   logic            OVF;

   modport master (
      output SR, CE, DIR, SRINIT, LOAD, LDVAL, CLR_OVF,
      input  DOUT, TC, OVF
   );

   modport slave (
      input  SR, CE, DIR, SRINIT, LOAD, LDVAL, CLR_OVF,
      output DOUT, TC, OVF
   );

endinterface

// File: rtl/counter_next_calc.sv
// Combinational next-count and boundary detection.
// Arithmetic is SIZE+1 wide so MODULUS = 2**SIZE fits.
module counter_next_calc
   import counter_pkg::*;
#(
   parameter int          SIZE    = 8,
   parameter int          MODULUS = 2**SIZE,
   parameter count_mode_t MODE    = COUNT_WRAP
) (
   input  logic [SIZE-1:0] dout,
   input  logic            sr,
   input  logic [SIZE-1:0] srinit,
   input  logic            load,
   input  logic [SIZE-1:0] ldval,
   input  logic            ce,
   input  logic            dir,
   output logic [SIZE-1:0] nxt,
   output logic            tc
);

   localparam logic [SIZE:0] MAXV = (SIZE+1)'(MODULUS - 1);

   logic [SIZE:0] cur;
   logic [SIZE:0] up_v;
   logic [SIZE:0] dn_v;
   logic [SIZE:0] sr_c;
   logic [SIZE:0] ld_c;
   logic [SIZE:0] wrap_v;
   logic [SIZE:0] nxt_w;
   logic          bnd;

   assign cur    = {1'b0, dout};
   assign up_v   = cur + 1'b1;
   assign dn_v   = cur - 1'b1;
   assign sr_c   = ({1'b0, srinit} > MAXV) ? MAXV : {1'b0, srinit};
   assign ld_c   = ({1'b0, ldval} > MAXV) ? MAXV : {1'b0, ldval};
   assign bnd    = (dir == DIR_UP) ? (cur == MAXV) : (cur == '0);
   assign wrap_v = (dir == DIR_UP) ? '0 : MAXV;
   assign tc     = ce & ~load & ~sr & bnd;

   // Overlapping controls resolve in order: reset, load, count.
   always_comb begin
      nxt_w = cur;
      priority case (1'b1)
         sr:          nxt_w = sr_c;
         load:        nxt_w = ld_c;
         ce && !bnd:  nxt_w = (dir == DIR_UP) ? up_v : dn_v;
         ce && (MODE == COUNT_WRAP):
                      nxt_w = wrap_v;
         default:     nxt_w = cur;
      endcase
   end

   assign nxt = nxt_w[SIZE-1:0];

endmodule

// File: rtl/modulo_updown_counter.sv
// Modulo up/down counter with load, wrap/saturate and sticky overflow.
// Holds only the count and overflow registers; next state is external.
module modulo_updown_counter
   import counter_pkg::*;
#(
   parameter int          SIZE    = 8,
   parameter int          MODULUS = 2**SIZE,
   parameter count_mode_t MODE    = COUNT_WRAP
) (
   input  logic            CLK,
   input  logic            SR,
   input  logic            CE,
   input  logic            DIR,
   input  logic [SIZE-1:0] SRINIT,
   input  logic            LOAD,
   input  logic [SIZE-1:0] LDVAL,
   input  logic            CLR_OVF,
   output logic [SIZE-1:0] DOUT,
   output logic            TC,
   output logic            OVF
);

   logic [SIZE-1:0] nxt;
   logic            tc_w;

   counter_next_calc #(
      .SIZE    (SIZE),
      .MODULUS (MODULUS),
      .MODE    (MODE)
   ) u_calc (
      .dout   (DOUT),
      .sr     (SR),
      .srinit (SRINIT),
      .load   (LOAD),
      .ldval  (LDVAL),
      .ce     (CE),
      .dir    (DIR),
      .nxt    (nxt),
      .tc     (tc_w)
   );

   assign TC = tc_w;

   always_ff @(posedge CLK) begin
      DOUT <= nxt;
   end

   // A boundary event in the same cycle beats a clear request.
   always_ff @(posedge CLK) begin
      if (SR)
         OVF <= 1'b0;
      else if (tc_w)
         OVF <= 1'b1;
      else if (CLR_OVF)
         OVF <= 1'b0;
   end

endmodule

// File: tb/tb_modulo_updown_counter.sv
// Scoreboard bench: three counters (wrap/10, sat/10, wrap/16) share stimulus.
// Expected values come from a behavioural model pushed to a queue.
module tb_modulo_updown_counter;
   import counter_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       sr = 1'b0;
   logic       ce = 1'b0;
   logic       dir = 1'b0;
   logic       ld = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] init = '0;
   logic [3:0] ldv = '0;

   modulo_updown_counter_if #(.SIZE(4)) u0 ();
   modulo_updown_counter_if #(.SIZE(4)) u1 ();
   modulo_updown_counter_if #(.SIZE(4)) u2 ();

   assign u0.SR = sr;  assign u1.SR = sr;  assign u2.SR = sr;
   assign u0.CE = ce;  assign u1.CE = ce;  assign u2.CE = ce;
   assign u0.DIR = dir; assign u1.DIR = dir; assign u2.DIR = dir;
   assign u0.SRINIT = init; assign u1.SRINIT = init; assign u2.SRINIT = init;
   assign u0.LOAD = ld; assign u1.LOAD = ld; assign u2.LOAD = ld;
   assign u0.LDVAL = ldv; assign u1.LDVAL = ldv; assign u2.LDVAL = ldv;
   assign u0.CLR_OVF = clr; assign u1.CLR_OVF = clr; assign u2.CLR_OVF = clr;

   modulo_updown_counter #(.SIZE(4), .MODULUS(10), .MODE(COUNT_WRAP)) dut0 (
      .CLK(clk), .SR(u0.SR), .CE(u0.CE), .DIR(u0.DIR), .SRINIT(u0.SRINIT),
      .LOAD(u0.LOAD), .LDVAL(u0.LDVAL), .CLR_OVF(u0.CLR_OVF),
      .DOUT(u0.DOUT), .TC(u0.TC), .OVF(u0.OVF));

   modulo_updown_counter #(.SIZE(4), .MODULUS(10), .MODE(COUNT_SAT)) dut1 (
      .CLK(clk), .SR(u1.SR), .CE(u1.CE), .DIR(u1.DIR), .SRINIT(u1.SRINIT),
      .LOAD(u1.LOAD), .LDVAL(u1.LDVAL), .CLR_OVF(u1.CLR_OVF),
      .DOUT(u1.DOUT), .TC(u1.TC), .OVF(u1.OVF));

   modulo_updown_counter #(.SIZE(4), .MODULUS(16), .MODE(COUNT_WRAP)) dut2 (
      .CLK(clk), .SR(u2.SR), .CE(u2.CE), .DIR(u2.DIR), .SRINIT(u2.SRINIT),
      .LOAD(u2.LOAD), .LDVAL(u2.LDVAL), .CLR_OVF(u2.CLR_OVF),
      .DOUT(u2.DOUT), .TC(u2.TC), .OVF(u2.OVF));

   logic [3:0] d_o [3];
   logic       t_o [3];
   logic       o_o [3];
   assign d_o[0] = u0.DOUT; assign d_o[1] = u1.DOUT; assign d_o[2] = u2.DOUT;
   assign t_o[0] = u0.TC;   assign t_o[1] = u1.TC;   assign t_o[2] = u2.TC;
   assign o_o[0] = u0.OVF;  assign o_o[1] = u1.OVF;  assign o_o[2] = u2.OVF;

   int mm [3] = '{10, 10, 16};
   bit ms [3] = '{1'b0, 1'b1, 1'b0};
   int md [3] = '{0, 0, 0};
   int mo [3] = '{0, 0, 0};

   typedef struct {
      string tag;
      int    idx;
      int    dout;
      int    ovf;
   } exp_t;
   exp_t q[$];

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input string tag, input bit s, input bit c,
                      input bit d, input bit l, input bit cl,
                      input int iv, input int lv);
      exp_t e;
      @(negedge clk);
      sr = s; ce = c; dir = d; ld = l; clr = cl;
      init = 4'(iv); ldv = 4'(lv);
      #1;
      for (int i = 0; i < 3; i++) begin
         int top;
         bit at_b;
         bit ev;
         top  = mm[i] - 1;
         at_b = d ? (md[i] == top) : (md[i] == 0);
         ev   = c && !l && !s && at_b;
         chk($sformatf("%s_tc%0d", tag, i), 32'(t_o[i]), 32'(ev));
         if (s) begin
            md[i] = (iv > top) ? top : iv;
            mo[i] = 0;
         end else begin
            if (l)
               md[i] = (lv > top) ? top : lv;
            else if (ev && !ms[i])
               md[i] = d ? 0 : top;
            else if (c && !ev)
               md[i] = d ? md[i] + 1 : md[i] - 1;
            if (ev)
               mo[i] = 1;
            else if (cl)
               mo[i] = 0;
         end
         e.tag = tag; e.idx = i; e.dout = md[i]; e.ovf = mo[i];
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
         e = q.pop_front();
         chk($sformatf("%s_dout%0d", e.tag, e.idx), 32'(d_o[e.idx]), e.dout);
         chk($sformatf("%s_ovf%0d", e.tag, e.idx), 32'(o_o[e.idx]), e.ovf);
      end
   endtask

   initial begin
      cyc("rst", 1, 0, 0, 0, 0, 3, 0);
      chk("rst_d0", 32'(d_o[0]), 3);
      chk("rst_o0", 32'(o_o[0]), 0);
      for (int k = 0; k < 7; k++)
         cyc("up7", 0, 1, DIR_UP, 0, 0, 0, 0);
      chk("wrap_d0", 32'(d_o[0]), 0);
      chk("wrap_o0", 32'(o_o[0]), 1);
      chk("sat_up_d1", 32'(d_o[1]), 9);

      cyc("hold", 0, 0, 1, 0, 0, 0, 0);
      cyc("ld1", 0, 0, 0, 1, 1, 0, 1);
      for (int k = 0; k < 3; k++)
         cyc("dn3", 0, 1, DIR_DOWN, 0, 0, 0, 0);
      chk("sat_dn_d1", 32'(d_o[1]), 0);
      chk("sat_dn_o1", 32'(o_o[1]), 1);

      cyc("ldclamp", 0, 1, 1, 1, 0, 0, 14);
      chk("ldclamp_d0", 32'(d_o[0]), 9);
      chk("ldclamp_d2", 32'(d_o[2]), 14);
      cyc("srclamp", 1, 0, 0, 0, 0, 12, 0);
      chk("srclamp_d0", 32'(d_o[0]), 9);

      cyc("ovfset", 0, 1, 1, 0, 0, 0, 0);
      cyc("clrev", 0, 1, 0, 0, 1, 0, 0);
      chk("clrev_o0", 32'(o_o[0]), 1);
      cyc("clr", 0, 0, 0, 0, 1, 0, 0);
      chk("clr_o0", 32'(o_o[0]), 0);

      cyc("ld15", 0, 0, 1, 1, 0, 0, 15);
      cyc("m16up", 0, 1, 1, 0, 0, 0, 0);
      chk("m16up_d2", 32'(d_o[2]), 0);
      cyc("m16dn", 0, 1, 0, 0, 0, 0, 0);
      chk("m16dn_d2", 32'(d_o[2]), 15);

      cyc("srall", 1, 1, 0, 1, 0, 5, 7);
      chk("srall_d2", 32'(d_o[2]), 5);
      chk("srall_o2", 32'(o_o[2]), 0);

      for (int k = 0; k < 60; k++)
         cyc("rnd", ($urandom_range(15) == 0), ($urandom_range(3) != 0),
             1'($urandom_range(1)), ($urandom_range(7) == 0),
             ($urandom_range(7) == 0), int'($urandom_range(15)),
             int'($urandom_range(15)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
